// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Collects "&&"-delimited frames from a UART byte stream into a payload
// buffer. A lone '&' followed by a non-'&' byte is payload data; "&&" inside
// a frame closes it. Reports good frames (frame_done/frame_len) and aborted
// frames (frame_err) as one-cycle pulses, and exposes the buffer through a
// registered read port.

module uart_frame_rx #(
  parameter int MAX_LEN     = 128,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_vld,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 frame_len,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       rx_busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    AMP_CHAR  = 8'h26;
  localparam logic [8:0]    MAX_LEN9  = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF1    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_AMP     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // True when 'add' more bytes still fit in the buffer after 'cnt' bytes.
  // Widened to 9 bits so cnt = 255 cannot wrap.
  function automatic logic room_for(input logic [7:0] cnt, input logic [8:0] add);
    return (({1'b0, cnt} + add) <= MAX_LEN9);
  endfunction

  // Registers
  state_t        r_state;
  logic [7:0]    r_count;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_frame_len;
  logic [7:0]    r_rd_data;
  logic          r_done;
  logic          r_err;
  logic          r_busy;
  logic [7:0]    r_buf [MAX_LEN];

  // Combinational next-state / write-port signals
  state_t        w_state_nxt;
  logic [7:0]    w_count_nxt;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic          w_err;
  logic          w_is_amp;
  logic          w_in_frame;
  logic          w_tmo_hit;

  assign w_is_amp   = (rx_data == AMP_CHAR);
  assign w_in_frame = (r_state == ST_SOF1) || (r_state == ST_PAYLOAD) || (r_state == ST_AMP);
  // The counter has already sat at the limit for a whole cycle: the frame
  // is stale. This takes priority over a strobe arriving in the same cycle.
  assign w_tmo_hit  = w_in_frame && (r_tmo == TMO_LIMIT);

  // Next-state, byte-count and buffer-write decode for the frame parser.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_we        = 1'b0;
    w_waddr     = r_count[AW-1:0];
    w_wdata     = rx_data;
    w_err       = 1'b0;

    if (w_tmo_hit) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_vld && w_is_amp) begin
            w_state_nxt = ST_SOF1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_SOF1: begin
          if (rx_vld) begin
            if (w_is_amp) begin
              w_state_nxt = ST_PAYLOAD;
              w_count_nxt = 8'd0;
            end else begin
              // Stray single '&' outside a frame: silently resync.
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_SOF1;
          end
        end

        ST_PAYLOAD: begin
          if (rx_vld) begin
            if (w_is_amp) begin
              // Park the '&' at buf[count] speculatively; it becomes data
              // only if the next byte is not '&'. Count is not advanced.
              if (room_for(r_count, 9'd1)) begin
                w_we    = 1'b1;
                w_wdata = AMP_CHAR;
              end else begin
                w_we    = 1'b0;
              end
              w_state_nxt = ST_AMP;
            end else if (room_for(r_count, 9'd1)) begin
              w_we        = 1'b1;
              w_count_nxt = r_count + 8'd1;
              w_state_nxt = ST_PAYLOAD;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end

        ST_AMP: begin
          if (rx_vld) begin
            if (w_is_amp) begin
              // Closing "&&": the parked '&' lies beyond count and is dropped.
              w_state_nxt = ST_DONE;
            end else if (room_for(r_count, 9'd2)) begin
              // Escaped '&' plus this byte: both become payload.
              w_we        = 1'b1;
              w_waddr     = r_count[AW-1:0] + ADDR_ONE;
              w_count_nxt = r_count + 8'd2;
              w_state_nxt = ST_PAYLOAD;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_AMP;
          end
        end

        ST_DONE: begin
          // Single-cycle state; a strobe here is treated as in IDLE.
          if (rx_vld && w_is_amp) begin
            w_state_nxt = ST_SOF1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and byte-count registers; reset abandons any frame in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Inter-byte idle counter: cleared by every strobe, saturates at the limit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tmo <= '0;
    end else if (rx_vld) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_LIMIT) begin
      r_tmo <= r_tmo + ADDR_ONE_TW();
    end else begin
      r_tmo <= r_tmo;
    end
  end

  // Constant one at the timer width (keeps the increment width-exact).
  function automatic logic [TW-1:0] ADDR_ONE_TW();
    return TW'(1);
  endfunction

  // Status outputs, registered from the next-state decode so they line up
  // with the cycle after the causing strobe or timeout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_len <= 8'd0;
    end else begin
      r_done <= (w_state_nxt == ST_DONE);
      r_err  <= w_err;
      r_busy <= (w_state_nxt == ST_PAYLOAD) || (w_state_nxt == ST_AMP);
      if (w_state_nxt == ST_DONE) begin
        r_frame_len <= r_count;
      end else begin
        r_frame_len <= r_frame_len;
      end
    end
  end

  // Payload buffer write port; contents survive reset by design.
  always_ff @(posedge sys_clk) begin
    if (w_we && !sys_rst) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

  // Registered read port; a same-cycle write to the same address is not
  // visible until the following read (old data is returned).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_data <= 8'd0;
    end else begin
      r_rd_data <= r_buf[rd_addr];
    end
  end

  assign rd_data    = r_rd_data;
  assign frame_len  = r_frame_len;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign rx_busy    = r_busy;

endmodule
